vga_layer_compositor: RTL and testbench

Parametrised, pipelined successor to the single-cycle screen painter. Composes border, obstacles, trail particles, player sprite and start/game-over images into one 12-bit RGB stream. Channel counts are generics, and ROM reads are pipelined to match the compositing path. Adds frame-synchronous mode switching, a game-over fade-in and a pause blink. Sits between the VGA timing generator (pixel coordinates in) and the VGA output driver (rgb out).

---
 rtl/vga_comp_pkg.sv | 55 +++++
 rtl/vga_hit_scan.sv | 35 +++
 rtl/vga_layer_compositor.sv | 239 +++++++++++++++++++++++
 tb/tb_vga_layer_compositor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_comp_pkg.sv
// Shared types, colour constants and colour helpers for the VGA layer compositor.
package vga_comp_pkg;

    typedef enum logic [1:0] {
        MODE_START = 2'b00,
        MODE_PLAY  = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_OVER  = 2'b11
    } mode_e;

    localparam logic [11:0] BORDER     = 12'h000;
    localparam logic [11:0] OBSTACLE   = 12'hFA0;
    localparam logic [11:0] BACKGROUND = 12'hFFF;
    localparam logic [11:0] PAUSE      = 12'hFF0;

    // Particles fade from a bright pink towards a dull blue as their life runs out.
    function automatic logic [11:0] trail_colour(input logic [3:0] life);
        logic [11:0] c;
        case (life)
            4'd10:   c = 12'hFDD;
            4'd9:    c = 12'hEEF;
            4'd8:    c = 12'hDDF;
            4'd7:    c = 12'hCCF;
            4'd6:    c = 12'hBBE;
            4'd5:    c = 12'hAAD;
            4'd4:    c = 12'h99C;
            4'd3:    c = 12'h88B;
            4'd2:    c = 12'h77A;
            4'd1:    c = 12'h669;
            default: c = BACKGROUND;
        endcase
        return c;
    endfunction

    // Per-channel linear mix in sixteenths; lvl=16 gives pure fg, lvl=0 pure bg.
    function automatic logic [11:0] blend(input logic [11:0] fg,
                                          input logic [11:0] bg,
                                          input logic [4:0]  lvl);
        logic [11:0] res;
        logic [8:0]  f9;
        logic [8:0]  b9;
        logic [8:0]  l9;
        logic [8:0]  acc;
        res = '0;
        l9  = {4'b0, lvl};
        for (int c = 0; c < 3; c++) begin
            f9  = {5'b0, fg[c*4 +: 4]};
            b9  = {5'b0, bg[c*4 +: 4]};
            acc = f9 * l9 + b9 * (9'd16 - l9);
            res[c*4 +: 4] = acc[7:4];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_hit_scan.sv
// Rectangle-array hit detector: reports whether a point lies inside any enabled
// half-open rectangle [left,right) x [up,down) and the lowest index that does.
module vga_hit_scan #(
    parameter int N  = 10,
    parameter int XW = 11,
    parameter int YW = 11,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [XW-1:0]   x_i,
    input  logic [YW-1:0]   y_i,
    input  logic [N-1:0]    en_i,
    input  logic [N*XW-1:0] left_i,
    input  logic [N*XW-1:0] right_i,
    input  logic [N*YW-1:0] up_i,
    input  logic [N*YW-1:0] down_i,
    output logic            hit_o,
    output logic [IW-1:0]   idx_o
);

    // Scan from the top index down so the lowest hitting index wins; inverted
    // rectangles can never satisfy both bounds and so never hit.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (en_i[i] &&
                x_i >= left_i[i*XW +: XW] && x_i < right_i[i*XW +: XW] &&
                y_i >= up_i[i*YW +: YW]   && y_i < down_i[i*YW +: YW]) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// Three-stage pixel compositor: S0 registers coordinates and drives ROM
// addresses, S1 resolves region hits while ROM data returns, S2 picks and
// blends the final colour.
module vga_layer_compositor
    import vga_comp_pkg::*;
#(
    parameter int NUM_OBS      = 10,
    parameter int NUM_TRAIL    = 28,
    parameter int TRAIL_SIZE   = 8,
    parameter int PLAYER_X     = 160,
    parameter int PLAYER_SIZE  = 40,
    parameter int GO_X         = 220,
    parameter int GO_Y         = 140,
    parameter int GO_SIZE      = 200,
    parameter int UPPER_BOUND  = 20,
    parameter int LOWER_BOUND  = 460,
    parameter int FADE_FRAMES  = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    input  logic                    frame_start,
    input  logic [9:0]              pix_x,
    input  logic [8:0]              pix_y,
    input  logic [1:0]              gamemode,
    input  logic [8:0]              player_y,
    input  logic [NUM_OBS*10-1:0]   obs_left,
    input  logic [NUM_OBS*10-1:0]   obs_right,
    input  logic [NUM_OBS*9-1:0]    obs_up,
    input  logic [NUM_OBS*9-1:0]    obs_down,
    input  logic [NUM_TRAIL*10-1:0] trail_x,
    input  logic [NUM_TRAIL*9-1:0]  trail_y,
    input  logic [NUM_TRAIL*4-1:0]  trail_life,
    output logic [18:0]             start_addr,
    output logic [10:0]             player_addr,
    output logic [15:0]             go_addr,
    input  logic [11:0]             start_data,
    input  logic [11:0]             player_data,
    input  logic [11:0]             go_data,
    output logic [11:0]             rgb,
    output logic                    rgb_valid
);

    localparam int FW  = $clog2(FADE_FRAMES) + 1;
    localparam int BW  = $clog2(BLINK_FRAMES) + 1;
    localparam int TIW = (NUM_TRAIL > 1) ? $clog2(NUM_TRAIL) : 1;
    localparam int OIW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

    mode_e          mode_q, mode_d;
    logic [4:0]     fadeLvl_q, fadeLvl_d;
    logic [FW-1:0]  fadeCnt_q, fadeCnt_d;
    logic [BW-1:0]  blinkCnt_q, blinkCnt_d;
    logic           blinkOn_q, blinkOn_d;

    // Frame-synchronous mode latch plus fade and blink counters; all advance only on frame_start.
    always_comb begin
        mode_d     = mode_q;
        fadeLvl_d  = fadeLvl_q;
        fadeCnt_d  = fadeCnt_q;
        blinkCnt_d = blinkCnt_q;
        blinkOn_d  = blinkOn_q;
        if (mode_q != MODE_OVER) begin
            fadeLvl_d = '0;
            fadeCnt_d = '0;
        end else if (frame_start) begin
            if (fadeCnt_q == FW'(FADE_FRAMES - 1)) begin
                fadeCnt_d = '0;
                if (fadeLvl_q != 5'd16) fadeLvl_d = fadeLvl_q + 5'd1;
            end else begin
                fadeCnt_d = fadeCnt_q + FW'(1);
            end
        end
        if (mode_q != MODE_PAUSE) begin
            blinkCnt_d = '0;
            blinkOn_d  = 1'b1;
        end else if (frame_start) begin
            if (blinkCnt_q == BW'(BLINK_FRAMES - 1)) begin
                blinkCnt_d = '0;
                blinkOn_d  = ~blinkOn_q;
            end else begin
                blinkCnt_d = blinkCnt_q + BW'(1);
            end
        end
        if (frame_start) mode_d = mode_e'(gamemode);
    end

    // Register the frame-level state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_START;
            fadeLvl_q  <= '0;
            fadeCnt_q  <= '0;
            blinkCnt_q <= '0;
            blinkOn_q  <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            fadeLvl_q  <= fadeLvl_d;
            fadeCnt_q  <= fadeCnt_d;
            blinkCnt_q <= blinkCnt_d;
            blinkOn_q  <= blinkOn_d;
        end
    end

    logic [10:0] xW, yW, pyW, pRow;
    logic        playerHit, goHit;
    logic [10:0] playerAddr_d;
    logic [15:0] goAddr_d;
    logic [18:0] startAddr_d;

    // S0 sprite hits and ROM addresses, widened to 11 bits so bottom/right edges cannot wrap.
    always_comb begin
        xW   = {1'b0, pix_x};
        yW   = {2'b0, pix_y};
        pyW  = {2'b0, player_y};
        pRow = yW - pyW;
        playerHit = (xW >= 11'(PLAYER_X)) && (xW < 11'(PLAYER_X + PLAYER_SIZE)) &&
                    (yW >= pyW) && (yW < pyW + 11'(PLAYER_SIZE));
        goHit     = (xW >= 11'(GO_X)) && (xW < 11'(GO_X + GO_SIZE)) &&
                    (yW >= 11'(GO_Y)) && (yW < 11'(GO_Y + GO_SIZE));
        playerAddr_d = playerHit ? (xW - 11'(PLAYER_X)) + pRow * 11'(PLAYER_SIZE) : '0;
        goAddr_d     = goHit ? {5'b0, xW - 11'(GO_X)} + {5'b0, yW - 11'(GO_Y)} * 16'(GO_SIZE) : '0;
        startAddr_d  = {9'b0, pix_x} + {10'b0, pix_y} * 19'd640;
    end

    logic [10:0] x0_q, y0_q;
    logic        v0_q, player0_q, go0_q, blink0_q;
    mode_e       mode0_q;
    logic [4:0]  fade0_q;
    logic [18:0] startAddr_q;
    logic [10:0] playerAddr_q;
    logic [15:0] goAddr_q;

    // S0 pipeline register; the pixel captures the pre-update frame state.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q <= '0; y0_q <= '0; v0_q <= 1'b0; player0_q <= 1'b0; go0_q <= 1'b0;
            mode0_q <= MODE_START; fade0_q <= '0; blink0_q <= 1'b1;
            startAddr_q <= '0; playerAddr_q <= '0; goAddr_q <= '0;
        end else begin
            x0_q <= xW; y0_q <= yW; v0_q <= pix_valid; player0_q <= playerHit; go0_q <= goHit;
            mode0_q <= mode_q; fade0_q <= fadeLvl_q; blink0_q <= blinkOn_q;
            startAddr_q <= startAddr_d; playerAddr_q <= playerAddr_d; goAddr_q <= goAddr_d;
        end
    end

    assign start_addr  = startAddr_q;
    assign player_addr = playerAddr_q;
    assign go_addr     = goAddr_q;

    logic [NUM_OBS*11-1:0]   obsLeftW, obsRightW, obsUpW, obsDownW;
    logic [NUM_TRAIL*11-1:0] trLeftW, trRightW, trUpW, trDownW;
    logic [NUM_TRAIL-1:0]    trEn;
    logic                    obsHit, trHit;
    logic [OIW-1:0]          obsIdx;
    logic [TIW-1:0]          trIdx;

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_obs
        assign obsLeftW[i*11 +: 11]  = {1'b0, obs_left[i*10 +: 10]};
        assign obsRightW[i*11 +: 11] = {1'b0, obs_right[i*10 +: 10]};
        assign obsUpW[i*11 +: 11]    = {2'b0, obs_up[i*9 +: 9]};
        assign obsDownW[i*11 +: 11]  = {2'b0, obs_down[i*9 +: 9]};
    end

    for (genvar i = 0; i < NUM_TRAIL; i++) begin : g_trail
        assign trLeftW[i*11 +: 11]  = {1'b0, trail_x[i*10 +: 10]};
        assign trRightW[i*11 +: 11] = {1'b0, trail_x[i*10 +: 10]} + 11'(TRAIL_SIZE);
        assign trUpW[i*11 +: 11]    = {2'b0, trail_y[i*9 +: 9]};
        assign trDownW[i*11 +: 11]  = {2'b0, trail_y[i*9 +: 9]} + 11'(TRAIL_SIZE);
        assign trEn[i]              = |trail_life[i*4 +: 4];
    end

    vga_hit_scan #(.N(NUM_OBS), .XW(11), .YW(11), .IW(OIW)) u_obs_scan (
        .x_i(x0_q), .y_i(y0_q), .en_i({NUM_OBS{1'b1}}),
        .left_i(obsLeftW), .right_i(obsRightW), .up_i(obsUpW), .down_i(obsDownW),
        .hit_o(obsHit), .idx_o(obsIdx)
    );

    vga_hit_scan #(.N(NUM_TRAIL), .XW(11), .YW(11), .IW(TIW)) u_trail_scan (
        .x_i(x0_q), .y_i(y0_q), .en_i(trEn),
        .left_i(trLeftW), .right_i(trRightW), .up_i(trUpW), .down_i(trDownW),
        .hit_o(trHit), .idx_o(trIdx)
    );

    logic        v1_q, border1_q, player1_q, go1_q, obs1_q, trail1_q, blink1_q;
    mode_e       mode1_q;
    logic [4:0]  fade1_q;
    logic [3:0]  life1_q;

    // S1 register of region flags and the winning particle's life, aligned with ROM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; border1_q <= 1'b0; player1_q <= 1'b0; go1_q <= 1'b0;
            obs1_q <= 1'b0; trail1_q <= 1'b0; blink1_q <= 1'b1;
            mode1_q <= MODE_START; fade1_q <= '0; life1_q <= '0;
        end else begin
            v1_q      <= v0_q;
            border1_q <= (y0_q <= 11'(UPPER_BOUND)) || (y0_q >= 11'(LOWER_BOUND));
            player1_q <= player0_q;
            go1_q     <= go0_q;
            obs1_q    <= obsHit;
            trail1_q  <= trHit;
            life1_q   <= trail_life[{trIdx, 2'b00} +: 4];
            blink1_q  <= blink0_q;
            mode1_q   <= mode0_q;
            fade1_q   <= fade0_q;
        end
    end

    logic [11:0] under, colour;

    // S2 priority chain, then mode-specific override or fade blend.
    always_comb begin
        under = BACKGROUND;
        if (border1_q)      under = BORDER;
        else if (player1_q) under = player_data;
        else if (obs1_q)    under = OBSTACLE;
        else if (trail1_q)  under = trail_colour(life1_q);
        colour = under;
        case (mode1_q)
            MODE_START: colour = start_data;
            MODE_PAUSE: if (blink1_q) colour = PAUSE;
            MODE_OVER:  if (go1_q) colour = blend(go_data, under, fade1_q);
            default:    colour = under;
        endcase
    end

    // S2 output register; colour is forced to zero outside active pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= v1_q ? colour : 12'h000;
            rgb_valid <= v1_q;
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench for vga_layer_compositor: directed pixels push expected
// colours, a forked monitor pops and compares whenever rgb_valid is seen.
module tb_vga_layer_compositor;

    localparam int NO = 10;
    localparam int NT = 28;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pix_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic [9:0]       pix_x = '0;
    logic [8:0]       pix_y = '0;
    logic [1:0]       gamemode = 2'b00;
    logic [8:0]       player_y = 9'd300;
    logic [NO*10-1:0] obs_left = '0;
    logic [NO*10-1:0] obs_right = '0;
    logic [NO*9-1:0]  obs_up = '0;
    logic [NO*9-1:0]  obs_down = '0;
    logic [NT*10-1:0] trail_x = '0;
    logic [NT*9-1:0]  trail_y = '0;
    logic [NT*4-1:0]  trail_life = '0;
    logic [18:0]      start_addr;
    logic [10:0]      player_addr;
    logic [15:0]      go_addr;
    logic [11:0]      start_data = '0;
    logic [11:0]      player_data = '0;
    logic [11:0]      go_data = '0;
    logic [11:0]      rgb;
    logic             rgb_valid;
    logic [11:0]      goColour = 12'hFFF;

    int          posCnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] expRgb[$];
    int          expCyc[$];
    string       expName[$];

    vga_layer_compositor #(.NUM_OBS(NO), .NUM_TRAIL(NT), .FADE_FRAMES(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
        .pix_x(pix_x), .pix_y(pix_y), .gamemode(gamemode), .player_y(player_y),
        .obs_left(obs_left), .obs_right(obs_right), .obs_up(obs_up), .obs_down(obs_down),
        .trail_x(trail_x), .trail_y(trail_y), .trail_life(trail_life),
        .start_addr(start_addr), .player_addr(player_addr), .go_addr(go_addr),
        .start_data(start_data), .player_data(player_data), .go_data(go_data),
        .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) posCnt <= posCnt + 1;

    // ROM models with one cycle of read latency; player/start ROMs return their own address.
    always @(posedge clk) begin
        player_data <= {1'b0, player_addr};
        start_data  <= start_addr[11:0];
        go_data     <= goColour;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y,
                                 input logic [11:0] exp, input string name);
        pix_x = x;
        pix_y = y;
        pix_valid = 1'b1;
        expRgb.push_back(exp);
        expCyc.push_back(posCnt + 3);
        expName.push_back(name);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic frameStart();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expRgb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain_pending", expRgb.size(), 0);
        expRgb.delete();
        expCyc.delete();
        expName.delete();
    endtask

    task automatic setObs(input int i, input int l, input int r, input int u, input int d);
        obs_left[i*10 +: 10] = 10'(l);
        obs_right[i*10 +: 10] = 10'(r);
        obs_up[i*9 +: 9] = 9'(u);
        obs_down[i*9 +: 9] = 9'(d);
    endtask

    task automatic setTrail(input int i, input int x, input int y, input int life);
        trail_x[i*10 +: 10] = 10'(x);
        trail_y[i*9 +: 9] = 9'(y);
        trail_life[i*4 +: 4] = 4'(life);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (rgb_valid) begin
                        if (expRgb.size() == 0) begin
                            checkOutput("unexpected_rgb_valid", 32'(rgb), 32'hFFFF_FFFF);
                        end else begin
                            automatic logic [11:0] e = expRgb.pop_front();
                            automatic int c = expCyc.pop_front();
                            automatic string nm = expName.pop_front();
                            checkOutput(nm, 32'(rgb), 32'(e));
                            checkOutput({nm, "_latency"}, posCnt, c);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        checkOutput("reset_rgb", 32'(rgb), 0);
        checkOutput("reset_rgb_valid", 32'(rgb_valid), 0);
        checkOutput("reset_player_addr", 32'(player_addr), 0);
        checkOutput("reset_go_addr", 32'(go_addr), 0);
        checkOutput("reset_start_addr", 32'(start_addr), 0);
        rst = 1'b0;

        gamemode = 2'b01;
        frameStart();
        applyStimulus(10'd0, 9'd10, 12'h000, "border_row10");
        applyStimulus(10'd300, 9'd200, 12'hFFF, "background");
        drain();

        setObs(0, 300, 340, 100, 200);
        setObs(2, 450, 420, 0, 479);
        setTrail(5, 300, 150, 7);
        applyStimulus(10'd305, 9'd152, 12'hFA0, "obstacle_over_trail");
        applyStimulus(10'd339, 9'd199, 12'hFA0, "obstacle_last_inside");
        applyStimulus(10'd340, 9'd100, 12'hFFF, "obstacle_right_edge");
        applyStimulus(10'd430, 9'd300, 12'hFFF, "degenerate_obstacle");
        drain();
        setObs(0, 500, 540, 100, 200);
        applyStimulus(10'd305, 9'd152, 12'hCCF, "trail_life7");
        applyStimulus(10'd307, 9'd157, 12'hCCF, "trail_last_inside");
        applyStimulus(10'd308, 9'd152, 12'hFFF, "trail_right_edge");
        applyStimulus(10'd305, 9'd158, 12'hFFF, "trail_bottom_edge");
        drain();

        setTrail(5, 0, 0, 0);
        setTrail(0, 100, 300, 0);
        setTrail(3, 100, 300, 2);
        setTrail(9, 100, 300, 10);
        setTrail(1, 200, 300, 0);
        applyStimulus(10'd103, 9'd303, 12'h77A, "trail_lowest_index");
        applyStimulus(10'd107, 9'd307, 12'h77A, "trail_overlap_corner");
        applyStimulus(10'd202, 9'd302, 12'hFFF, "trail_life0_ignored");
        drain();

        trail_life = '0;
        setObs(0, 300, 340, 180, 220);
        gamemode = 2'b10;
        applyStimulus(10'd310, 9'd200, 12'hFA0, "pause_midframe_no_effect");
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFF0, "pause_frame0");
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFF0, "pause_frame1");
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFA0, "pause_frame2");
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFA0, "pause_frame3");
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFF0, "pause_frame4");
        frameStart();
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFA0, "pause_frame6");
        gamemode = 2'b01;
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFA0, "pause_left");
        gamemode = 2'b10;
        frameStart();
        applyStimulus(10'd310, 9'd200, 12'hFF0, "pause_restart_on");
        drain();

        goColour = 12'hFFF;
        gamemode = 2'b11;
        frameStart();
        applyStimulus(10'd230, 9'd150, 12'hFFF, "go_white_over_bg");
        drain();
        goColour = 12'h000;
        @(negedge clk);
        applyStimulus(10'd310, 9'd200, 12'hFA0, "fade0_obstacle");
        for (int i = 0; i < 4; i++) frameStart();
        applyStimulus(10'd310, 9'd200, 12'hE90, "fade1_obstacle");
        applyStimulus(10'd230, 9'd150, 12'hEEE, "fade1_background");
        for (int i = 0; i < 60; i++) frameStart();
        applyStimulus(10'd310, 9'd200, 12'h000, "fade16_obstacle");
        applyStimulus(10'd230, 9'd150, 12'h000, "fade16_background");
        for (int i = 0; i < 4; i++) frameStart();
        applyStimulus(10'd310, 9'd200, 12'h000, "fade_saturated");
        applyStimulus(10'd100, 9'd400, 12'hFFF, "over_outside_go");
        drain();

        gamemode = 2'b00;
        frameStart();
        applyStimulus(10'd5, 9'd2, 12'h505, "start_image");
        drain();

        gamemode = 2'b01;
        frameStart();
        player_y = 9'd450;
        applyStimulus(10'd160, 9'd459, 12'h168, "player_sprite");
        checkOutput("player_addr_160_459", 32'(player_addr), 360);
        applyStimulus(10'd160, 9'd460, 12'h000, "border_over_player");
        applyStimulus(10'd199, 9'd450, 12'h027, "player_right_col");
        applyStimulus(10'd200, 9'd450, 12'hFFF, "player_right_edge");
        checkOutput("player_addr_outside", 32'(player_addr), 0);
        applyStimulus(10'd230, 9'd150, 12'hFFF, "go_rect_in_play");
        checkOutput("go_addr_230_150", 32'(go_addr), 2010);
        drain();

        gamemode = 2'b10;
        frame_start = 1'b1;
        applyStimulus(10'd300, 9'd250, 12'hFFF, "fs_same_cycle_old_mode");
        frame_start = 1'b0;
        applyStimulus(10'd300, 9'd250, 12'hFF0, "fs_next_pixel_new_mode");
        drain();

        pix_x = 10'd300;
        pix_y = 9'd250;
        pix_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        @(negedge clk);
        checkOutput("midline_reset_rgb_valid", 32'(rgb_valid), 0);
        checkOutput("midline_reset_rgb", 32'(rgb), 0);
        rst = 1'b0;
        applyStimulus(10'd5, 9'd2, 12'h505, "post_reset_first_pixel");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
